// File: rtl/aes_gctr_sequencer_pkg.sv
// Shared AES-GCM constants for the GCTR sequencer: block/IV widths, counter
// width, sequencer state encoding and the inc32 helper.
package aes_gctr_sequencer_pkg;

  localparam int AES_NB_BLOCK = 128;
  localparam int AES_NB_IV    = 96;
  localparam int AES_NB_CTR   = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE_J0 = 2'd1,
    ST_RUN      = 2'd2,
    ST_DRAIN    = 2'd3
  } seq_state_t;

  // Low 32-bit counter increment; wraps without touching the IV bits.
  function automatic logic [AES_NB_CTR-1:0] inc32(input logic [AES_NB_CTR-1:0] v);
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/aes_seq_out_fifo.sv
// First-word-fall-through output FIFO for GCTR results. The head word is
// presented whenever the FIFO is non-empty; the output reads as zero when empty.
module aes_seq_out_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              rd_go;
  logic              full;

  assign valid   = (cnt != '0);
  assign full    = (cnt == DEPTH_L);
  assign rd_go   = rd_en && valid;
  assign rd_data = valid ? mem[rd_ptr] : '0;
  assign count   = cnt;

  // Storage array; data is not reset, only the pointers/count are.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous write+read keeps count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_go) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_go})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // The credit scheme upstream must make a write into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule

// File: rtl/aes_gctr_sequencer.sv
// AES-GCTR block sequencer: issues J0 then one counter block per accepted
// data block to an external round ladder, gathers results into an output
// FIFO under credit-based flow control, and captures E(K, J0) for the tag.
// When NB_IV equals NB_BLOCK the IV port carries a pre-derived J0 block.
module aes_gctr_sequencer
  import aes_gctr_sequencer_pkg::*;
#(
  parameter int NB_BLOCK   = AES_NB_BLOCK,
  parameter int NB_IV      = AES_NB_IV,
  parameter int NB_LEN     = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [NB_IV-1:0]    i_iv,
  input  logic [NB_LEN-1:0]   i_n_blocks,
  input  logic [NB_BLOCK-1:0] i_data,
  input  logic                i_data_valid,
  output logic                o_data_ready,
  output logic [NB_BLOCK-1:0] o_ladder_state,
  output logic [NB_BLOCK-1:0] o_ladder_data,
  output logic                o_ladder_valid,
  input  logic [NB_BLOCK-1:0] i_ladder_data,
  input  logic [NB_BLOCK-1:0] i_ladder_state,
  input  logic                i_ladder_valid,
  output logic [NB_BLOCK-1:0] o_data,
  output logic                o_data_valid,
  input  logic                i_data_ready,
  output logic [NB_BLOCK-1:0] o_ek_j0,
  output logic                o_ek_j0_valid,
  output logic                o_busy,
  output logic                o_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  seq_state_t             state;
  logic [NB_IV-1:0]       iv_q;
  logic [NB_LEN-1:0]      n_blocks_q;
  logic [NB_LEN-1:0]      issued;
  logic [NB_LEN-1:0]      issued_nxt;
  logic [AES_NB_CTR-1:0]  ctr;
  logic [CW-1:0]          inflight;
  logic                   j0_pending;
  logic [NB_BLOCK-1:0]    ek_j0_q;
  logic                   ek_j0_valid_q;
  logic                   done_q;
  logic [NB_BLOCK-1:0]    j0_blk;
  logic [CW:0]            occupancy;
  logic                   has_credit;
  logic                   issue_j0;
  logic                   accept;
  logic                   fifo_wr;
  logic                   fifo_rd;
  logic                   fifo_valid;
  logic [CW-1:0]          fifo_count;
  logic [NB_BLOCK-1:0]    fifo_dout;

  // J0 is either IV || 0^31 || 1 or, for a full-width IV port, the IV itself.
  generate
    if (NB_IV == NB_BLOCK) begin : g_full_j0
      assign j0_blk = iv_q;
    end else begin : g_iv96_j0
      assign j0_blk = {iv_q, 32'd1};
    end
  endgenerate

  // J0 occupies a credit while in flight even though it bypasses the FIFO.
  assign occupancy  = {1'b0, fifo_count} + {1'b0, inflight};
  assign has_credit = (occupancy < DEPTH_L);
  assign issued_nxt = issued + NB_LEN'(1);

  assign issue_j0       = (state == ST_ISSUE_J0);
  assign o_data_ready   = (state == ST_RUN) && has_credit && (issued < n_blocks_q);
  assign accept         = o_data_ready && i_data_valid;
  assign o_ladder_valid = issue_j0 || accept;
  assign o_ladder_state = issue_j0 ? j0_blk :
                          accept   ? {j0_blk[NB_BLOCK-1:AES_NB_CTR], ctr} : '0;
  assign o_ladder_data  = accept ? i_data : '0;

  assign fifo_wr      = i_ladder_valid && !j0_pending;
  assign fifo_rd      = fifo_valid && i_data_ready;
  assign o_data       = fifo_dout;
  assign o_data_valid = fifo_valid;

  assign o_ek_j0       = ek_j0_q;
  assign o_ek_j0_valid = ek_j0_valid_q;
  assign o_busy        = (state != ST_IDLE);
  assign o_done        = done_q;

  // Message parameters captured on an accepted start; pure data, no reset.
  always_ff @(posedge i_clock) begin
    if (state == ST_IDLE && i_start) begin
      iv_q       <= i_iv;
      n_blocks_q <= i_n_blocks;
    end
  end

  // Sequencer FSM, counter, in-flight tracking and E(K, J0) capture.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      issued        <= '0;
      ctr           <= '0;
      inflight      <= '0;
      j0_pending    <= 1'b0;
      ek_j0_q       <= '0;
      ek_j0_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            issued        <= '0;
            ek_j0_valid_q <= 1'b0;
            j0_pending    <= 1'b1;
            state         <= ST_ISSUE_J0;
          end
        end
        ST_ISSUE_J0: begin
          ctr   <= inc32(j0_blk[AES_NB_CTR-1:0]);
          state <= (n_blocks_q == '0) ? ST_DRAIN : ST_RUN;
        end
        ST_RUN: begin
          if (accept) begin
            ctr    <= inc32(ctr);
            issued <= issued_nxt;
            if (issued_nxt == n_blocks_q) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (inflight == '0 && fifo_count == '0) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      case ({o_ladder_valid, i_ladder_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase

      // J0 carries zero data, so its keystream output is E(K, J0) directly.
      if (i_ladder_valid && j0_pending) begin
        ek_j0_q       <= i_ladder_state;
        ek_j0_valid_q <= 1'b1;
        j0_pending    <= 1'b0;
      end
    end
  end

  aes_seq_out_fifo #(
    .DATA_W (NB_BLOCK),
    .DEPTH  (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (i_clock),
    .rst     (i_reset),
    .wr_en   (fifo_wr),
    .wr_data (i_ladder_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_dout),
    .valid   (fifo_valid),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_aes_gctr_sequencer.sv
// Bench for aes_gctr_sequencer: a fixed-latency ladder responder, two DUTs
// (96-bit IV and full-width J0 port) sharing it, and per-scenario tasks.
module tb_aes_gctr_sequencer;

  localparam int DEPTH = 8;
  localparam int LAT   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, sel, din_valid, dout_ready;
  logic [127:0] iv, din;
  logic [15:0]  n_in;
  int           vld_pct, rdy_pct;

  logic         a_dready, a_lv, a_dv, a_ekv, a_busy, a_done;
  logic [127:0] a_lst, a_ld, a_dout, a_ek;
  logic         b_dready, b_lv, b_dv, b_ekv, b_busy, b_done;
  logic [127:0] b_lst, b_ld, b_dout, b_ek;
  logic         lad_v;
  logic [127:0] lad_st, lad_d;

  aes_gctr_sequencer #(.NB_BLOCK(128), .NB_IV(96), .NB_LEN(16), .FIFO_DEPTH(DEPTH)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_start(start & ~sel), .i_iv(iv[95:0]), .i_n_blocks(n_in),
    .i_data(din), .i_data_valid(din_valid & ~sel), .o_data_ready(a_dready),
    .o_ladder_state(a_lst), .o_ladder_data(a_ld), .o_ladder_valid(a_lv),
    .i_ladder_data(lad_d), .i_ladder_state(lad_st), .i_ladder_valid(lad_v & ~sel),
    .o_data(a_dout), .o_data_valid(a_dv), .i_data_ready(dout_ready),
    .o_ek_j0(a_ek), .o_ek_j0_valid(a_ekv), .o_busy(a_busy), .o_done(a_done));

  aes_gctr_sequencer #(.NB_BLOCK(128), .NB_IV(128), .NB_LEN(16), .FIFO_DEPTH(DEPTH)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_start(start & sel), .i_iv(iv), .i_n_blocks(n_in),
    .i_data(din), .i_data_valid(din_valid & sel), .o_data_ready(b_dready),
    .o_ladder_state(b_lst), .o_ladder_data(b_ld), .o_ladder_valid(b_lv),
    .i_ladder_data(lad_d), .i_ladder_state(lad_st), .i_ladder_valid(lad_v & sel),
    .o_data(b_dout), .o_data_valid(b_dv), .i_data_ready(dout_ready),
    .o_ek_j0(b_ek), .o_ek_j0_valid(b_ekv), .o_busy(b_busy), .o_done(b_done));

  wire          m_dready = sel ? b_dready : a_dready;
  wire          m_lv     = sel ? b_lv     : a_lv;
  wire          m_dv     = sel ? b_dv     : a_dv;
  wire          m_ekv    = sel ? b_ekv    : a_ekv;
  wire          m_busy   = sel ? b_busy   : a_busy;
  wire          m_done   = sel ? b_done   : a_done;
  wire [127:0]  m_lst    = sel ? b_lst    : a_lst;
  wire [127:0]  m_ld     = sel ? b_ld     : a_ld;
  wire [127:0]  m_dout   = sel ? b_dout   : a_dout;
  wire [127:0]  m_ek     = sel ? b_ek     : a_ek;

  // Stand-in block cipher: any fixed bijection serves as the keystream.
  function automatic logic [127:0] ks(input logic [127:0] s);
    return {s[95:0], s[127:96]} ^ 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  endfunction

  function automatic logic [127:0] model_j0(input logic [127:0] v, input bit full);
    return full ? v : {v[95:0], 32'd1};
  endfunction

  // Counter block k: upper J0 bits untouched, low word = J0 low + 1 + k mod 2^32.
  function automatic logic [127:0] model_ctr(input logic [127:0] j0, input int k);
    logic [31:0] lo;
    lo = j0[31:0] + 32'(k) + 32'd1;
    return {j0[127:32], lo};
  endfunction

  // Ladder responder: fixed LAT-cycle pipeline, cleared by the shared reset.
  logic         p_v  [LAT];
  logic [127:0] p_st [LAT];
  logic [127:0] p_d  [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) p_v[i] <= 1'b0;
    end else begin
      for (int i = LAT-1; i > 0; i--) begin
        p_v[i] <= p_v[i-1]; p_st[i] <= p_st[i-1]; p_d[i] <= p_d[i-1];
      end
      p_v[0]  <= m_lv;
      p_st[0] <= ks(m_lst);
      p_d[0]  <= m_ld ^ ks(m_lst);
    end
  end
  assign lad_v  = p_v[LAT-1];
  assign lad_st = p_st[LAT-1];
  assign lad_d  = p_d[LAT-1];

  logic [127:0] lad_st_q[$], lad_d_q[$], acc_q[$], out_q[$];
  int           acc_cyc[$], out_cyc[$];
  int           dones, ek_rises, cyc;
  bit           ekv_prev;
  int           n_cmp, n_bad;

  // Monitor: records issues, accepted inputs, delivered outputs and pulses.
  always @(posedge clk) begin
    if (!rst) begin
      if (m_lv) begin lad_st_q.push_back(m_lst); lad_d_q.push_back(m_ld); end
      if (m_dready && din_valid) begin acc_q.push_back(din); acc_cyc.push_back(cyc); end
      if (m_dv && dout_ready) begin out_q.push_back(m_dout); out_cyc.push_back(cyc); end
      if (m_ekv && !ekv_prev) ek_rises++;
      if (m_done) dones++;
    end
    ekv_prev = m_ekv;
    cyc++;
  end

  task automatic clear_obs();
    lad_st_q.delete(); lad_d_q.delete(); acc_q.delete(); out_q.delete();
    acc_cyc.delete(); out_cyc.delete(); dones = 0; ek_rises = 0;
  endtask

  task automatic run_cycles(input int max_cyc, input bit until_done);
    for (int i = 0; i < max_cyc; i++) begin
      din        = {$urandom, $urandom, $urandom, $urandom};
      din_valid  = ($urandom_range(0, 99) < vld_pct);
      dout_ready = ($urandom_range(0, 99) < rdy_pct);
      @(posedge clk); #1;
      if (until_done && dones > 0) break;
    end
  endtask

  task automatic start_msg(input logic [127:0] v, input int n);
    clear_obs();
    iv = v; n_in = 16'(n); start = 1'b1;
    run_cycles(1, 1'b0);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (m_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", m_busy); end
    n_cmp++; if ({m_dv, m_dready, m_lv, m_ekv, m_done} !== 5'b0) begin n_bad++; $display("FAIL reset_strobes got %b want 00000", {m_dv, m_dready, m_lv, m_ekv, m_done}); end
    n_cmp++; if ({m_dout, m_ek, m_lst, m_ld} !== 512'b0) begin n_bad++; $display("FAIL reset_buses got nonzero want 0"); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [127:0] v, j0;
    v = {32'h0, 96'hCAFEBABEFACEDBADDECAF888};
    j0 = model_j0(v, 1'b0);
    sel = 1'b0; vld_pct = 100; rdy_pct = 100;
    start_msg(v, 4);
    n_cmp++; if (m_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy got %b want 1", m_busy); end
    run_cycles(500, 1'b1);
    n_cmp++; if (lad_st_q.size() !== 5) begin n_bad++; $display("FAIL basic_issues got %0d want 5", lad_st_q.size()); end
    for (int k = 0; k < 5 && k < lad_st_q.size(); k++) begin
      n_cmp++;
      if (lad_st_q[k] !== {v[95:0], 32'(k + 1)}) begin n_bad++; $display("FAIL basic_state[%0d] got %h want %h", k, lad_st_q[k], {v[95:0], 32'(k + 1)}); end
    end
    n_cmp++; if (lad_d_q.size() > 0 && lad_d_q[0] !== 128'b0) begin n_bad++; $display("FAIL basic_j0_data got %h want 0", lad_d_q[0]); end
    n_cmp++; if (ek_rises !== 1) begin n_bad++; $display("FAIL basic_ek_rises got %0d want 1", ek_rises); end
    n_cmp++; if (m_ek !== ks(j0)) begin n_bad++; $display("FAIL basic_ek got %h want %h", m_ek, ks(j0)); end
    n_cmp++; if (out_q.size() !== 4) begin n_bad++; $display("FAIL basic_outs got %0d want 4", out_q.size()); end
    for (int k = 0; k < 4 && k < out_q.size() && k < acc_q.size(); k++) begin
      n_cmp++;
      if (out_q[k] !== (acc_q[k] ^ ks(model_ctr(j0, k)))) begin n_bad++; $display("FAIL basic_out[%0d] got %h want %h", k, out_q[k], acc_q[k] ^ ks(model_ctr(j0, k))); end
      n_cmp++;
      if (lad_d_q[k+1] !== acc_q[k]) begin n_bad++; $display("FAIL basic_ladder_data[%0d] got %h want %h", k, lad_d_q[k+1], acc_q[k]); end
    end
    n_cmp++; if (dones !== 1 || m_busy !== 1'b0) begin n_bad++; $display("FAIL basic_done got dones=%0d busy=%b want 1/0", dones, m_busy); end
  endtask

  task automatic test_zero_len();
    logic [127:0] v;
    v = {32'h0, $urandom, $urandom, $urandom};
    sel = 1'b0; vld_pct = 100; rdy_pct = 100;
    start_msg(v, 0);
    run_cycles(200, 1'b1);
    n_cmp++; if (lad_st_q.size() !== 1) begin n_bad++; $display("FAIL zero_issues got %0d want 1", lad_st_q.size()); end
    n_cmp++; if (m_ek !== ks(model_j0(v, 1'b0)) || m_ekv !== 1'b1) begin n_bad++; $display("FAIL zero_ek got %h/%b want %h/1", m_ek, m_ekv, ks(model_j0(v, 1'b0))); end
    n_cmp++; if (out_q.size() !== 0) begin n_bad++; $display("FAIL zero_outs got %0d want 0", out_q.size()); end
    n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL zero_done got %0d want 1", dones); end
  endtask

  task automatic test_ctr_wrap();
    logic [127:0] v;
    logic [31:0]  exp_lo [3];
    exp_lo = '{32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    v = {$urandom, $urandom, $urandom, 32'hFFFFFFFE};
    sel = 1'b1; vld_pct = 80; rdy_pct = 100;
    start_msg(v, 3);
    run_cycles(500, 1'b1);
    n_cmp++; if (lad_st_q.size() !== 4) begin n_bad++; $display("FAIL wrap_issues got %0d want 4", lad_st_q.size()); end
    for (int k = 0; k < 3 && k + 1 < lad_st_q.size(); k++) begin
      n_cmp++;
      if (lad_st_q[k+1] !== {v[127:32], exp_lo[k]}) begin n_bad++; $display("FAIL wrap_state[%0d] got %h want %h", k, lad_st_q[k+1], {v[127:32], exp_lo[k]}); end
    end
    for (int k = 0; k < 3 && k < out_q.size() && k < acc_q.size(); k++) begin
      n_cmp++;
      if (out_q[k] !== (acc_q[k] ^ ks({v[127:32], exp_lo[k]}))) begin n_bad++; $display("FAIL wrap_out[%0d] got %h", k, out_q[k]); end
    end
    n_cmp++; if (dones !== 1 || out_q.size() !== 3) begin n_bad++; $display("FAIL wrap_done got dones=%0d outs=%0d want 1/3", dones, out_q.size()); end
    sel = 1'b0;
  endtask

  task automatic test_random();
    for (int m = 0; m < 5; m++) begin
      logic [127:0] v, j0;
      int n;
      v = {32'h0, $urandom, $urandom, $urandom};
      j0 = model_j0(v, 1'b0);
      n = $urandom_range(1, 24);
      sel = 1'b0; vld_pct = $urandom_range(30, 100); rdy_pct = $urandom_range(20, 100);
      start_msg(v, n);
      run_cycles(3000, 1'b1);
      n_cmp++; if (out_q.size() !== n || dones !== 1) begin n_bad++; $display("FAIL rand%0d_count got outs=%0d dones=%0d want %0d/1", m, out_q.size(), dones, n); end
      for (int k = 0; k < n && k < out_q.size() && k < acc_q.size() && k + 1 < lad_st_q.size(); k++) begin
        n_cmp++;
        if (lad_st_q[k+1] !== model_ctr(j0, k) || out_q[k] !== (acc_q[k] ^ ks(model_ctr(j0, k)))) begin
          n_bad++; $display("FAIL rand%0d_blk[%0d] got state=%h out=%h want state=%h", m, k, lad_st_q[k+1], out_q[k], model_ctr(j0, k));
        end
      end
    end
  endtask

  task automatic test_throughput();
    int n;
    n = 20;
    sel = 1'b0; vld_pct = 100; rdy_pct = 100;
    start_msg({32'h0, $urandom, $urandom, $urandom}, n);
    run_cycles(500, 1'b1);
    if (acc_cyc.size() == n && out_cyc.size() == n) begin
      n_cmp++; if (acc_cyc[n-1] - acc_cyc[0] !== n - 1) begin n_bad++; $display("FAIL tput_issue_span got %0d want %0d", acc_cyc[n-1] - acc_cyc[0], n - 1); end
      n_cmp++; if (out_cyc[0] - acc_cyc[0] !== LAT + 1) begin n_bad++; $display("FAIL tput_latency got %0d want %0d", out_cyc[0] - acc_cyc[0], LAT + 1); end
      n_cmp++; if (out_cyc[n-1] - out_cyc[0] !== n - 1) begin n_bad++; $display("FAIL tput_out_span got %0d want %0d", out_cyc[n-1] - out_cyc[0], n - 1); end
    end else begin
      n_cmp++; n_bad++; $display("FAIL tput_counts got acc=%0d out=%0d want %0d", acc_cyc.size(), out_cyc.size(), n);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] v, j0;
    v = {32'h0, $urandom, $urandom, $urandom};
    j0 = model_j0(v, 1'b0);
    sel = 1'b0; vld_pct = 100; rdy_pct = 0;
    start_msg(v, 64);
    run_cycles(40, 1'b0);
    n_cmp++; if (acc_q.size() !== DEPTH) begin n_bad++; $display("FAIL bp_accepted got %0d want %0d", acc_q.size(), DEPTH); end
    n_cmp++; if (m_dready !== 1'b0 || m_dv !== 1'b1) begin n_bad++; $display("FAIL bp_stall got ready=%b valid=%b want 0/1", m_dready, m_dv); end
    n_cmp++; if (out_q.size() !== 0) begin n_bad++; $display("FAIL bp_no_out got %0d want 0", out_q.size()); end
    rdy_pct = 70;
    run_cycles(4000, 1'b1);
    n_cmp++; if (out_q.size() !== 64 || dones !== 1) begin n_bad++; $display("FAIL bp_count got outs=%0d dones=%0d want 64/1", out_q.size(), dones); end
    for (int k = 0; k < 64 && k < out_q.size() && k < acc_q.size(); k++) begin
      n_cmp++;
      if (out_q[k] !== (acc_q[k] ^ ks(model_ctr(j0, k)))) begin n_bad++; $display("FAIL bp_out[%0d] got %h want %h", k, out_q[k], acc_q[k] ^ ks(model_ctr(j0, k))); end
    end
  endtask

  task automatic test_midreset();
    logic [127:0] v, j0;
    sel = 1'b0; vld_pct = 100; rdy_pct = 100;
    start_msg({32'h0, $urandom, $urandom, $urandom}, 30);
    run_cycles(5, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({m_busy, m_dv, m_dready, m_lv, m_ekv, m_done} !== 6'b0) begin n_bad++; $display("FAIL midrst_strobes got %b want 000000", {m_busy, m_dv, m_dready, m_lv, m_ekv, m_done}); end
    n_cmp++; if ({m_dout, m_ek, m_lst} !== 384'b0) begin n_bad++; $display("FAIL midrst_buses got nonzero want 0"); end
    rst = 1'b0;
    v = {32'h0, $urandom, $urandom, $urandom};
    j0 = model_j0(v, 1'b0);
    start_msg(v, 6);
    run_cycles(500, 1'b1);
    n_cmp++; if (out_q.size() !== 6 || dones !== 1 || lad_st_q.size() !== 7) begin n_bad++; $display("FAIL midrst_restart got outs=%0d dones=%0d issues=%0d want 6/1/7", out_q.size(), dones, lad_st_q.size()); end
    for (int k = 0; k < 6 && k < out_q.size() && k < acc_q.size(); k++) begin
      n_cmp++;
      if (out_q[k] !== (acc_q[k] ^ ks(model_ctr(j0, k)))) begin n_bad++; $display("FAIL midrst_out[%0d] got %h", k, out_q[k]); end
    end
  endtask

  task automatic test_start_busy();
    logic [127:0] v, j0;
    v = {32'h0, $urandom, $urandom, $urandom};
    j0 = model_j0(v, 1'b0);
    sel = 1'b0; vld_pct = 100; rdy_pct = 100;
    start_msg(v, 10);
    run_cycles(3, 1'b0);
    iv = ~v; n_in = 16'd3; start = 1'b1;
    run_cycles(1, 1'b0);
    start = 1'b0;
    run_cycles(1000, 1'b1);
    n_cmp++; if (lad_st_q.size() !== 11 || out_q.size() !== 10 || dones !== 1) begin n_bad++; $display("FAIL busy_start_counts got issues=%0d outs=%0d dones=%0d want 11/10/1", lad_st_q.size(), out_q.size(), dones); end
    for (int k = 0; k < 10 && k + 1 < lad_st_q.size(); k++) begin
      n_cmp++;
      if (lad_st_q[k+1] !== model_ctr(j0, k)) begin n_bad++; $display("FAIL busy_start_state[%0d] got %h want %h", k, lad_st_q[k+1], model_ctr(j0, k)); end
    end
    n_cmp++; if (m_busy !== 1'b0) begin n_bad++; $display("FAIL busy_start_idle got %b want 0", m_busy); end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; ekv_prev = 1'b0;
    start = 1'b0; sel = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    iv = '0; n_in = '0; vld_pct = 100; rdy_pct = 100; rst = 1'b1;
    clear_obs();
    test_reset();
    test_basic();
    test_zero_len();
    test_ctr_wrap();
    test_random();
    test_throughput();
    test_backpressure();
    test_midreset();
    test_start_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
